// File: rtl/pwm_generator.sv
// Fixed-period PWM generator with a shadowed duty-cycle register.
// A new duty value is loaded into the shadow register through a valid/ready
// handshake. It becomes active only at a period boundary, so a period is
// never cut short or stretched. Dropping enable lets the current period run
// to completion (DRAIN) before the block goes idle.
module pwm_generator #(
  parameter int PERIOD       = 1000,
  parameter int CNT_W        = 10,
  parameter int DUTY_W       = 11,
  parameter int DEFAULT_DUTY = 0
) (
  input  logic              clk_1MHz,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DUTY_W-1:0] duty_in,
  input  logic              duty_valid,
  output logic              duty_ready,
  output logic              pwm_out,
  output logic              period_done,
  output logic              busy,
  output logic [1:0]        fsm_state
);

  // Handshake: a transfer happens on a rising clock edge where
  // duty_valid & duty_ready are both 1. duty_ready depends only on internal
  // state, never on duty_valid. The master holds duty_in/duty_valid until
  // the transfer happens; while duty_ready is 0, duty_in is ignored.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [DUTY_W-1:0] PERIOD_D  = DUTY_W'(PERIOD);
  localparam logic [DUTY_W-1:0] DUTY_RST  = DUTY_W'(DEFAULT_DUTY);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              pending;
  logic [DUTY_W-1:0] shadow;
  logic [DUTY_W-1:0] duty_active;
  logic [DUTY_W-1:0] duty_active_nxt;
  logic [DUTY_W-1:0] duty_eff_nxt;
  logic              pwm_nxt;
  logic              period_done_nxt;
  logic              at_end;
  logic              xfer;

  // Last cycle of a period while the waveform is active.
  assign at_end     = (state != IDLE) && (cnt == CNT_LAST);
  assign duty_ready = ~pending;
  assign xfer       = duty_valid & duty_ready;
  assign busy       = (state != IDLE);
  assign fsm_state  = state;

  // State register.
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: enable always wins; without it, finish the period first.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enable) state_nxt = RUN;
      end
      RUN, DRAIN: begin
        if (enable)      state_nxt = RUN;
        else if (at_end) state_nxt = IDLE;
        else             state_nxt = DRAIN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter and duty values for the next cycle; registered outputs are built
  // from these so pwm_out lines up with the period index it describes.
  always_comb begin
    cnt_nxt         = cnt + 1'b1;
    duty_active_nxt = duty_active;
    if ((state == IDLE) || at_end) begin
      cnt_nxt = '0;
    end
    if ((state == IDLE) && xfer) begin
      duty_active_nxt = duty_in;
    end else if (at_end && pending) begin
      duty_active_nxt = shadow;
    end
  end

  // Output logic: high while k < min(duty, PERIOD); period_done on k = 0.
  always_comb begin
    duty_eff_nxt    = (duty_active_nxt > PERIOD_D) ? PERIOD_D : duty_active_nxt;
    pwm_nxt         = (state_nxt != IDLE) && (DUTY_W'(cnt_nxt) < duty_eff_nxt);
    period_done_nxt = (state_nxt != IDLE) && ((state == IDLE) || at_end);
  end

  // Counter, shadow register and active duty.
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      pending     <= 1'b0;
      shadow      <= '0;
      duty_active <= DUTY_RST;
    end else begin
      cnt         <= cnt_nxt;
      duty_active <= duty_active_nxt;
      if (at_end && pending) begin
        pending <= 1'b0;
      end
      // A write in the boundary cycle is only possible with pending = 0, so
      // it lands in the shadow and waits for the following boundary.
      if ((state != IDLE) && xfer) begin
        shadow  <= duty_in;
        pending <= 1'b1;
      end
    end
  end

  // Registered waveform outputs.
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out     <= 1'b0;
      period_done <= 1'b0;
    end else begin
      pwm_out     <= pwm_nxt;
      period_done <= period_done_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator: a table of whole-period checks while
// running, plus hand-written sequences for drain/resume, stop, idle writes
// and reset with a pending duty value.
module tb_pwm_generator;

  localparam int PERIOD = 1000;
  localparam int DUTY_W = 11;

  // ---------------- clock / reset ----------------
  logic              clk_1MHz = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [DUTY_W-1:0] duty_in;
  logic              duty_valid;
  logic              duty_ready;
  logic              pwm_out;
  logic              period_done;
  logic              busy;
  logic [1:0]        fsm_state;

  always #5 clk_1MHz = ~clk_1MHz;

  pwm_generator #(
    .PERIOD(PERIOD), .CNT_W(10), .DUTY_W(DUTY_W), .DEFAULT_DUTY(0)
  ) dut (
    .clk_1MHz   (clk_1MHz),
    .rst_n      (rst_n),
    .enable     (enable),
    .duty_in    (duty_in),
    .duty_valid (duty_valid),
    .duty_ready (duty_ready),
    .pwm_out    (pwm_out),
    .period_done(period_done),
    .busy       (busy),
    .fsm_state  (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_pending;

  typedef struct {
    int exp_high;  // expected high cycles in this period
    int wr_k;      // period index at which to offer a new duty (-1 = none)
    int wr_val;    // duty value offered
  } vec_t;

  vec_t vecs[9];

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Runs exactly one period starting at the negedge of k = 0, checking each
  // cycle against the expected waveform; optionally offers a duty write and
  // toggles enable at chosen indices. Ends on the negedge of the next k = 0.
  task automatic check_period(input int exp_high, input int wr_k, input int wr_val,
                              input int drop_k, input int rise_k, input string name);
    int   wave_err = 0;
    int   high     = 0;
    int   pd_err   = 0;
    int   rdy_err  = 0;
    int   busy_err = 0;
    logic xf;
    for (int k = 0; k < PERIOD; k++) begin
      if (pwm_out === 1'b1) high++;
      if (pwm_out !== (k < exp_high)) wave_err++;
      if (period_done !== (k == 0)) pd_err++;
      if (duty_ready !== !exp_pending) rdy_err++;
      if (busy !== 1'b1) busy_err++;
      xf = 1'b0;
      if (k == wr_k) begin
        duty_in    = DUTY_W'(wr_val);
        duty_valid = 1'b1;
        xf         = !exp_pending;
      end else begin
        duty_valid = 1'b0;
      end
      if (k == drop_k) enable = 1'b0;
      if (k == rise_k) enable = 1'b1;
      // Boundary clears the old pending value; a write in this cycle survives.
      if (k == PERIOD - 1) exp_pending = xf;
      else if (xf)         exp_pending = 1'b1;
      @(negedge clk_1MHz);
    end
    duty_valid = 1'b0;
    check_eq({name, "_high_cycles"}, high, exp_high);
    check_eq({name, "_wave_errors"}, wave_err, 0);
    check_eq({name, "_period_done_errors"}, pd_err, 0);
    check_eq({name, "_ready_errors"}, rdy_err, 0);
    check_eq({name, "_busy_errors"}, busy_err, 0);
  endtask

  // Offers a duty value for one cycle while idle.
  task automatic idle_write(input int val, input string name);
    duty_in    = DUTY_W'(val);
    duty_valid = 1'b1;
    check_eq({name, "_ready_before"}, duty_ready, 1);
    @(negedge clk_1MHz);
    duty_valid = 1'b0;
    check_eq({name, "_ready_after"}, duty_ready, 1);
    check_eq({name, "_idle_pwm"}, pwm_out, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int idle_err;

    // Expected waveform period by period; each row's write shows up one row later
    // (two rows later when written in the boundary cycle k = 999).
    vecs[0] = '{exp_high: 250,  wr_k: 300, wr_val: 600};
    vecs[1] = '{exp_high: 600,  wr_k: 10,  wr_val: 0};
    vecs[2] = '{exp_high: 0,    wr_k: 500, wr_val: 1000};
    vecs[3] = '{exp_high: 1000, wr_k: 5,   wr_val: 2047};
    vecs[4] = '{exp_high: 1000, wr_k: 0,   wr_val: 1};
    vecs[5] = '{exp_high: 1,    wr_k: 999, wr_val: 999};
    vecs[6] = '{exp_high: 1,    wr_k: -1,  wr_val: 0};
    vecs[7] = '{exp_high: 999,  wr_k: 1,   wr_val: 250};
    vecs[8] = '{exp_high: 250,  wr_k: -1,  wr_val: 0};

    rst_n       = 1'b0;
    enable      = 1'b0;
    duty_in     = '0;
    duty_valid  = 1'b0;
    exp_pending = 1'b0;
    repeat (3) @(negedge clk_1MHz);

    check_eq("reset_pwm", pwm_out, 0);
    check_eq("reset_period_done", period_done, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_ready", duty_ready, 1);
    check_eq("reset_state", fsm_state, 0);

    rst_n = 1'b1;
    @(negedge clk_1MHz);

    // Idle write goes straight to the active duty.
    idle_write(250, "idle_250");
    enable = 1'b1;
    @(negedge clk_1MHz);
    check_eq("start_period_done", period_done, 1);
    check_eq("start_state", fsm_state, 1);

    for (int i = 0; i < 9; i++) begin
      check_period(vecs[i].exp_high, vecs[i].wr_k, vecs[i].wr_val, -1, -1,
                   $sformatf("vec%0d", i));
    end

    // Drop enable at k=400, restore at k=700: waveform must be unbroken.
    check_period(250, -1, 0, 400, 700, "drain_resume");
    // Drop and hold: period completes, then idle.
    check_period(250, -1, 0, 400, -1, "drain_stop");
    idle_err = 0;
    for (int k = 0; k < 20; k++) begin
      if (pwm_out !== 1'b0 || period_done !== 1'b0 || busy !== 1'b0) idle_err++;
      @(negedge clk_1MHz);
    end
    check_eq("idle_output_errors", idle_err, 0);
    check_eq("idle_state", fsm_state, 0);

    // Restart with a new idle-written duty.
    idle_write(700, "idle_700");
    enable = 1'b1;
    @(negedge clk_1MHz);
    check_eq("restart_period_done", period_done, 1);
    check_period(700, -1, 0, -1, -1, "run_700");

    // Reset at k=100 with a pending duty.
    for (int k = 0; k < 100; k++) begin
      duty_valid = (k == 50);
      duty_in    = DUTY_W'(300);
      @(negedge clk_1MHz);
    end
    duty_valid = 1'b0;
    check_eq("pre_reset_pwm", pwm_out, 1);
    check_eq("pre_reset_ready", duty_ready, 0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_reset_pwm", pwm_out, 0);
    check_eq("mid_reset_busy", busy, 0);
    check_eq("mid_reset_ready", duty_ready, 1);
    check_eq("mid_reset_state", fsm_state, 0);
    enable = 1'b0;
    @(negedge clk_1MHz);
    rst_n = 1'b1;
    @(negedge clk_1MHz);
    enable      = 1'b1;
    exp_pending = 1'b0;
    @(negedge clk_1MHz);
    check_eq("post_reset_period_done", period_done, 1);
    // Default duty is 0 and the pending 300 was discarded.
    check_period(0, -1, 0, -1, -1, "post_reset");

    enable = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
